noc_tx_arbiter: RTL

Round-robin arbiter that shares one CONNECT NoC injection port (putFlit/getCredits) among N local requesters: the controller's work dispatcher, the result reporter and the clock-count reporter. It formats granted payloads into the NoC flit layout, locks the port to one requester for a whole packet (head through tail), and tracks link credits so no flit is sent without a free downstream buffer. It sits between the requester logic and the NoC send interface of a node.

---
 rtl/noc_tx_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/noc_tx_arbiter.sv
// Shares one NoC injection port among N requesters: packet locking, flit formatting, link credits.
// Define TX_ARB_RR_EN for round-robin selection in IDLE; otherwise the lowest requester index wins.
module noc_tx_arbiter #(
  parameter int N           = 3,
  parameter int DATA_W      = 64,
  parameter int DEST_BITS   = 5,
  parameter int VC_BITS     = 2,
  parameter int VC          = 0,
  parameter int CREDITS     = 16,
  parameter int CREDIT_BITS = 5,
  localparam int OW         = $clog2(N),
  localparam int FLIT_W     = 2 + DATA_W + DEST_BITS + VC_BITS
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N*DATA_W-1:0]    req_data,
  input  logic [N*DEST_BITS-1:0] req_dest,
  input  logic [N-1:0]           req_tail,
  output logic [N-1:0]           grant,
  output logic [FLIT_W-1:0]      putFlit,
  output logic                   EN_putFlit,
  input  logic [VC_BITS:0]       getCredits,
  output logic                   EN_getCredits,
  output logic [OW-1:0]          owner,
  output logic                   locked,
  output logic                   credit_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state, state_nxt;
  logic [CREDIT_BITS-1:0] credit_cnt;
  logic [OW-1:0]          sel;
  logic                   found, send, sel_tail, cred_ret;

  assign locked   = (state == LOCKED);
  assign send     = found && (credit_cnt != '0);
  assign sel_tail = req_tail[sel];
  assign cred_ret = getCredits[VC_BITS] && (getCredits[VC_BITS-1:0] == VC_BITS'(VC));

`ifdef TX_ARB_RR_EN
  logic [OW-1:0] ptr;
  int            idx;
`endif

  // A locked owner is the only candidate; other requesters wait for its tail.
  always_comb begin
    sel   = '0;
    found = 1'b0;
`ifdef TX_ARB_RR_EN
    idx   = 0;
`endif
    if (state == LOCKED) begin
      found = req[owner];
      sel   = owner;
    end else begin
`ifdef TX_ARB_RR_EN
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found = 1'b1;
          sel   = OW'(idx);
        end
      end
`else
      for (int k = N - 1; k >= 0; k--) begin
        if (req[k]) begin
          found = 1'b1;
          sel   = OW'(k);
        end
      end
`endif
    end
  end

  always_comb begin
    grant      = '0;
    grant[sel] = send;
  end

  always_comb begin
    state_nxt = state;
    if (send) begin
      case (state)
        IDLE:    if (!sel_tail) state_nxt = LOCKED;
        LOCKED:  if (sel_tail)  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state         <= IDLE;
      putFlit       <= '0;
      EN_putFlit    <= 1'b0;
      EN_getCredits <= 1'b0;
      owner         <= '0;
      credit_err    <= 1'b0;
      credit_cnt    <= CREDIT_BITS'(CREDITS);
`ifdef TX_ARB_RR_EN
      ptr           <= '0;
`endif
    end else begin
      state         <= state_nxt;
      EN_getCredits <= 1'b1;
      EN_putFlit    <= send;
      putFlit       <= send ? {1'b1, sel_tail, req_dest[sel*DEST_BITS +: DEST_BITS],
                               VC_BITS'(VC), req_data[sel*DATA_W +: DATA_W]} : '0;
      if (send && state == IDLE && !sel_tail) owner <= sel;
      // A send and a matching return in the same cycle cancel out.
      if (send && !cred_ret) begin
        credit_cnt <= credit_cnt - 1'b1;
      end else if (!send && cred_ret) begin
        if (credit_cnt == CREDIT_BITS'(CREDITS)) credit_err <= 1'b1;
        else                                     credit_cnt <= credit_cnt + 1'b1;
      end
`ifdef TX_ARB_RR_EN
      if (send && sel_tail) ptr <= (sel == OW'(N - 1)) ? '0 : sel + 1'b1;
`endif
    end
  end

endmodule
